// File: rtl/prog_sequencer.sv
// Program-flow sequencer: PC, conditional/absolute/relative branches, call/return stack,
// Start/Ack handshake and run-cycle counter. Define SEQ_BRANCH_CNT_EN to add the BranchCt output.
module prog_sequencer #(
  parameter int PC_W    = 10,
  parameter int TGT_W   = 8,
  parameter int STACK_D = 4,
  parameter int CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             Halt,
  input  logic             Jump,
  input  logic [1:0]       Cond,
  input  logic             AbsOrRel,
  input  logic [TGT_W-1:0] Target,
  input  logic             Call,
  input  logic             Ret,
  input  logic             Zero,
  input  logic             Negative,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Taken,
  output logic             Ack,
  output logic [CNT_W-1:0] CycleCt,
  output logic             StackErr,
  output logic [1:0]       DbgState
`ifdef SEQ_BRANCH_CNT_EN
  ,
  output logic [CNT_W-1:0] BranchCt
`endif
);

  // Start/Ack handshake: Start is a level; Ack rises on Halt and only clears while in LOAD.
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} stateE;

  localparam int SP_W  = $clog2(STACK_D + 1);
  localparam int IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

  stateE           state;
  logic [PC_W-1:0] retStack [STACK_D];
  logic [SP_W-1:0] stackPtr;
  logic            stackEmpty, stackFull, condTrue, runActive, pushEn;
  logic [IDX_W-1:0] topIdx, pushIdx;
  logic [PC_W-1:0] pcInc, absTgt, relTgt;

  assign DbgState   = state;
  assign stackEmpty = (stackPtr == '0);
  assign stackFull  = (stackPtr == SP_W'(STACK_D));
  assign topIdx     = IDX_W'(stackPtr - SP_W'(1));
  assign pushIdx    = IDX_W'(stackPtr);
  assign pcInc      = ProgCtr + PC_W'(1);
  assign absTgt     = PC_W'(Target);
  assign relTgt     = ProgCtr + PC_W'($signed(Target));
  assign runActive  = (state == RUN) && !Start && !Halt;
  assign pushEn     = runActive && !Ret && Call && !stackFull;

  always_comb begin
    condTrue = 1'b1;
    case (Cond)
      2'b00:   condTrue = !Zero && !Negative;
      2'b01:   condTrue = !Zero && Negative;
      2'b10:   condTrue = Zero;
      default: condTrue = 1'b1;
    endcase
  end

  always_comb begin
    Taken = 1'b0;
    if (runActive) begin
      if (Ret)       Taken = !stackEmpty;
      else if (Call) Taken = 1'b1;
      else if (Jump) Taken = condTrue;
    end
  end

  // Stack storage needs no reset; only the pointer defines validity.
  always_ff @(posedge Clk) begin
    if (pushEn) retStack[pushIdx] <= pcInc;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      ProgCtr  <= '0;
      Ack      <= 1'b0;
      CycleCt  <= '0;
      StackErr <= 1'b0;
      stackPtr <= '0;
`ifdef SEQ_BRANCH_CNT_EN
      BranchCt <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) state <= LOAD;
        end
        LOAD: begin
          ProgCtr  <= StartAddr;
          CycleCt  <= '0;
          Ack      <= 1'b0;
          StackErr <= 1'b0;
          stackPtr <= '0;
`ifdef SEQ_BRANCH_CNT_EN
          BranchCt <= '0;
`endif
          if (!Start) state <= RUN;
        end
        RUN: begin
          if (Start) begin
            state <= LOAD;
          end else if (Halt) begin
            Ack   <= 1'b1;
            state <= DONE;
          end else begin
            if (CycleCt != '1) CycleCt <= CycleCt + CNT_W'(1);
`ifdef SEQ_BRANCH_CNT_EN
            if (Taken && (BranchCt != '1)) BranchCt <= BranchCt + CNT_W'(1);
`endif
            if (Ret) begin
              if (!stackEmpty) begin
                ProgCtr  <= retStack[topIdx];
                stackPtr <= stackPtr - SP_W'(1);
              end else begin
                ProgCtr  <= pcInc;
                StackErr <= 1'b1;
              end
            end else if (Call) begin
              // A call on a full stack still jumps; only the return address is lost.
              if (!stackFull) stackPtr <= stackPtr + SP_W'(1);
              else            StackErr <= 1'b1;
              ProgCtr <= absTgt;
            end else if (Jump && condTrue) begin
              ProgCtr <= AbsOrRel ? absTgt : relTgt;
            end else begin
              ProgCtr <= pcInc;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Randomized bench for prog_sequencer against a queue-based behavioural model;
// checks BranchCt too when SEQ_BRANCH_CNT_EN is defined.
module tb_prog_sequencer;

  localparam int PC_W    = 10;
  localparam int TGT_W   = 8;
  localparam int STACK_D = 2;
  localparam int CNT_W   = 4;
  localparam int PC_MASK = (1 << PC_W) - 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_DONE = 3;

  logic             clk, rst;
  logic             start, halt, jump, absOrRel, call, ret, zero, negative;
  logic [PC_W-1:0]  startAddr;
  logic [1:0]       cond;
  logic [TGT_W-1:0] target;
  logic [PC_W-1:0]  progCtr;
  logic             taken, ack, stackErr;
  logic [CNT_W-1:0] cycleCt;
  logic [1:0]       dbgState;
`ifdef SEQ_BRANCH_CNT_EN
  logic [CNT_W-1:0] branchCt;
`endif

  prog_sequencer #(.PC_W(PC_W), .TGT_W(TGT_W), .STACK_D(STACK_D), .CNT_W(CNT_W)) dut (
    .Clk(clk), .Reset(rst), .Start(start), .StartAddr(startAddr), .Halt(halt),
    .Jump(jump), .Cond(cond), .AbsOrRel(absOrRel), .Target(target), .Call(call),
    .Ret(ret), .Zero(zero), .Negative(negative), .ProgCtr(progCtr), .Taken(taken),
    .Ack(ack), .CycleCt(cycleCt), .StackErr(stackErr), .DbgState(dbgState)
`ifdef SEQ_BRANCH_CNT_EN
    , .BranchCt(branchCt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model and scoreboard
  int mMode, mPc, mCyc, mBr;
  bit mAck, mErr;
  int mStack[$];
  logic [PC_W-1:0] expQ[$];
  int nCompared = 0;
  int nMismatched = 0;
  logic tkSeen;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit condOk();
    case (cond)
      2'd0:    return !zero && !negative;
      2'd1:    return !zero && negative;
      2'd2:    return zero;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit modelTaken();
    if (mMode != M_RUN || start || halt) return 1'b0;
    if (ret)  return mStack.size() > 0;
    if (call) return 1'b1;
    if (jump) return condOk();
    return 1'b0;
  endfunction

  task automatic modelReset();
    mMode = M_IDLE; mPc = 0; mCyc = 0; mBr = 0; mAck = 0; mErr = 0;
    mStack.delete();
    expQ.delete();
  endtask

  task automatic modelStep();
    bit tk;
    int off;
    tk = modelTaken();
    case (mMode)
      M_IDLE, M_DONE: if (start) mMode = M_LOAD;
      M_LOAD: begin
        mPc = int'(startAddr); mCyc = 0; mBr = 0; mAck = 0; mErr = 0;
        mStack.delete();
        if (!start) mMode = M_RUN;
      end
      default: begin
        if (start) mMode = M_LOAD;
        else if (halt) begin
          mAck = 1; mMode = M_DONE;
        end else begin
          if (ret) begin
            if (mStack.size() > 0) mPc = mStack.pop_back();
            else begin mPc = mPc + 1; mErr = 1; end
          end else if (call) begin
            if (mStack.size() < STACK_D) mStack.push_back((mPc + 1) & PC_MASK);
            else mErr = 1;
            mPc = int'(target);
          end else if (jump && condOk()) begin
            off = int'(target);
            if (off > 127) off -= 256;
            mPc = absOrRel ? int'(target) : mPc + off;
          end else mPc = mPc + 1;
          mPc &= PC_MASK;
          if (mCyc < CNT_MAX) mCyc++;
          if (tk && mBr < CNT_MAX) mBr++;
        end
      end
    endcase
    expQ.push_back(PC_W'(mPc));
  endtask

  task automatic checkOutputs();
    logic [PC_W-1:0] expPc;
    expPc = expQ.pop_front();
    checkEq("pc", progCtr, expPc);
    checkEq("ack", ack, mAck);
    checkEq("cycle_ct", cycleCt, mCyc);
    checkEq("stack_err", stackErr, mErr);
`ifdef SEQ_BRANCH_CNT_EN
    checkEq("branch_ct", branchCt, mBr);
`endif
  endtask

  // drivers
  task automatic clearIns();
    start = 0; halt = 0; jump = 0; absOrRel = 0; call = 0; ret = 0;
    zero = 0; negative = 0; cond = 2'd0; target = '0;
  endtask

  task automatic tick();
    #1;
    tkSeen = taken;
    checkEq("taken", taken, modelTaken());
    @(posedge clk);
    modelStep();
    #1;
    checkOutputs();
  endtask

  task automatic startAt(input logic [PC_W-1:0] addr, input int nHigh);
    clearIns();
    start = 1; startAddr = addr;
    repeat (nHigh) tick();
    start = 0;
    tick();
  endtask

  initial begin
    clearIns();
    startAddr = '0;
    rst = 0;
    modelReset();
    #12;
    checkEq("rst_pc", progCtr, 0);
    checkEq("rst_ack", ack, 0);
    checkEq("rst_cyc", cycleCt, 0);
    checkEq("rst_err", stackErr, 0);
    checkEq("rst_taken", taken, 0);
    @(posedge clk); #1 rst = 1;

    // run from 0x010, five sequential steps, then halt
    startAt(10'h010, 3);
    repeat (5) tick();
    halt = 1; tick();
    checkEq("halt_pc", progCtr, 10'h015);
    checkEq("halt_cyc", cycleCt, 5);
    checkEq("halt_ack", ack, 1);
    for (int i = 0; i < 4; i++) begin
      halt = 1'($urandom); jump = 1'($urandom); call = 1'($urandom); ret = 1'($urandom);
      cond = 2'($urandom); target = 8'($urandom);
      tick();
      checkEq("done_ack", ack, 1);
      checkEq("done_pc", progCtr, 10'h015);
    end

    // conditional relative branch, taken then not taken
    startAt(10'h020, 2);
    jump = 1; cond = 2'd0; target = 8'hFC; tick();
    checkEq("gt_pc", progCtr, 10'h01C);
    checkEq("gt_taken", tkSeen, 1);
    startAt(10'h020, 2);
    jump = 1; cond = 2'd0; target = 8'hFC; negative = 1; tick();
    checkEq("gt_nt_pc", progCtr, 10'h021);
    checkEq("gt_nt_taken", tkSeen, 0);

    // wraparound
    startAt(10'h3FF, 2);
    tick();
    checkEq("wrap_seq", progCtr, 10'h000);
    startAt(10'h3FE, 2);
    jump = 1; cond = 2'd3; target = 8'h05; tick();
    checkEq("wrap_rel", progCtr, 10'h003);

    // call/return stack overflow and underflow
    startAt(10'h004, 2);
    call = 1; target = 8'h30; tick();
    target = 8'h50; tick();
    target = 8'h70; tick();
    checkEq("ovf_pc", progCtr, 10'h070);
    checkEq("ovf_err", stackErr, 1);
    call = 0; ret = 1; tick();
    checkEq("ret1_pc", progCtr, 10'h031);
    tick();
    checkEq("ret2_pc", progCtr, 10'h005);
    tick();
    checkEq("unf_pc", progCtr, 10'h006);
    checkEq("unf_taken", tkSeen, 0);
    ret = 0; tick();
    checkEq("err_sticky", stackErr, 1);
    startAt(10'h000, 2);
    checkEq("err_clr", stackErr, 0);

    // branch counting
    startAt(10'h100, 2);
    jump = 1; cond = 2'd3; target = 8'h01;
    repeat (3) tick();
    cond = 2'd2; zero = 0;
    repeat (2) tick();
`ifdef SEQ_BRANCH_CNT_EN
    checkEq("br_cnt", branchCt, 3);
    startAt(10'h000, 2);
    checkEq("br_clr", branchCt, 0);
`endif

    // cycle counter saturation
    startAt(10'h000, 2);
    repeat (CNT_MAX + 5) tick();
    checkEq("cyc_sat", cycleCt, CNT_MAX);

    // asynchronous reset mid-run
    startAt(10'h020, 2);
    repeat (5) tick();
    checkEq("pre_rst_pc", progCtr, 10'h025);
    #2 rst = 0;
    #1;
    checkEq("arst_pc", progCtr, 0);
    checkEq("arst_ack", ack, 0);
    checkEq("arst_cyc", cycleCt, 0);
    modelReset();
    @(posedge clk); @(posedge clk);
    #2 rst = 1;
    jump = 1; cond = 2'd3; target = 8'h40;
    repeat (2) tick();
    checkEq("idle_pc", progCtr, 0);

    // randomized instruction stream
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 39) == 0);
      startAddr = ($urandom_range(0, 3) == 0) ? 10'(10'h3F8 + $urandom_range(0, 7))
                                                : 10'($urandom_range(0, PC_MASK));
      halt      = ($urandom_range(0, 29) == 0);
      ret       = ($urandom_range(0, 5) == 0);
      call      = ($urandom_range(0, 5) == 0);
      jump      = ($urandom_range(0, 2) == 0);
      cond      = 2'($urandom);
      absOrRel  = 1'($urandom);
      target    = 8'($urandom_range(0, 255));
      zero      = 1'($urandom);
      negative  = 1'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
